// File: rtl/mipi_video_pkg.sv
// Shared constants and types for the MIPI DSI video timing driver.
// Default timing describes a 720x1280 portrait panel.
package mipi_video_pkg;

    localparam int RGB_W   = 24;
    localparam int COORD_W = 11;
    localparam int CNT_W   = 12;

    localparam int DEF_H_SYNC  = 10;
    localparam int DEF_H_BACK  = 40;
    localparam int DEF_H_DISP  = 720;
    localparam int DEF_H_FRONT = 40;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 16;
    localparam int DEF_V_DISP  = 1280;
    localparam int DEF_V_FRONT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vid_state_t;

endpackage

// File: rtl/timing_counter.sv
// Modulo-TOTAL counter used for both the horizontal and vertical timing axes.
// wrap is combinational so the next axis can chain its increment off it.
module timing_counter
    import mipi_video_pkg::*;
#(
    parameter int TOTAL = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = inc && (cnt == CNT_W'(TOTAL - 1));

    // NOTE: reset is synchronous, so it lives inside the clocked block and is
    // only sampled on the rising edge; state updates use <= so every register
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mipi_video_timing.sv
// Display timing driver: requests pixel coordinates from a 1-cycle-latency pixel
// source and realigns the returned RGB with regenerated hsync/vsync/de.
module mipi_video_timing
    import mipi_video_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter bit HS_POL  = 1'b1,
    parameter bit VS_POL  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vid_en,
    input  logic [RGB_W-1:0]   pixel_data,
    output logic [COORD_W-1:0] pixel_xpos,
    output logic [COORD_W-1:0] pixel_ypos,
    output logic [COORD_W-1:0] h_disp,
    output logic [COORD_W-1:0] v_disp,
    output logic               vid_hs,
    output logic               vid_vs,
    output logic               vid_de,
    output logic [RGB_W-1:0]   vid_data,
    output logic               frame_start,
    output logic               busy
);

    localparam int H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int HA_START = H_SYNC + H_BACK;
    localparam int VA_START = V_SYNC + V_BACK;

    vid_state_t       state;
    logic             running;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    logic h_act;
    logic v_act;
    logic active_now;

    logic active0;
    logic hs0;
    logic vs0;
    logic de1;
    logic hs1;
    logic vs1;

    assign running = (state != IDLE);
    assign h_disp  = COORD_W'(H_DISP);
    assign v_disp  = COORD_W'(V_DISP);

    timing_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (running),
        .clear (~running),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    timing_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (h_wrap),
        .clear (~running),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    assign h_act = (h_cnt >= CNT_W'(HA_START)) && (h_cnt < CNT_W'(HA_START + H_DISP));
    assign v_act = (v_cnt >= CNT_W'(VA_START)) && (v_cnt < CNT_W'(VA_START + V_DISP));
    assign active_now = running && h_act && v_act;

    // FSM plus stage 0: coordinates, raw syncs, frame_start and busy all share
    // this registered timing; v_wrap marks the last pixel of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active0     <= 1'b0;
            hs0         <= 1'b0;
            vs0         <= 1'b0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE:    if (vid_en) state <= RUN;
                RUN:     if (!vid_en) state <= DRAIN;
                DRAIN: begin
                    if (vid_en)      state <= RUN;
                    else if (v_wrap) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            active0     <= active_now;
            hs0         <= running && (h_cnt < CNT_W'(H_SYNC));
            vs0         <= running && (v_cnt < CNT_W'(V_SYNC));
            // Offsets fit in COORD_W whenever the active window is asserted.
            pixel_xpos  <= active_now ? (h_cnt[COORD_W-1:0] - COORD_W'(HA_START)) : '0;
            pixel_ypos  <= active_now ? (v_cnt[COORD_W-1:0] - COORD_W'(VA_START)) : '0;
            frame_start <= (state == RUN) && (h_cnt == '0) && (v_cnt == '0);
            busy        <= running;
        end
    end

    // Stage 1 lines up with pixel_data returned by the source; stage 2 drives the packetiser.
    always_ff @(posedge clk) begin
        if (rst) begin
            de1      <= 1'b0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
            vid_de   <= 1'b0;
            vid_hs   <= ~HS_POL;
            vid_vs   <= ~VS_POL;
            vid_data <= '0;
        end else begin
            de1      <= active0;
            hs1      <= hs0;
            vs1      <= vs0;
            vid_de   <= de1;
            vid_hs   <= hs1 ? HS_POL : ~HS_POL;
            vid_vs   <= vs1 ? VS_POL : ~VS_POL;
            vid_data <= de1 ? pixel_data : '0;
        end
    end

endmodule

// File: tb/tb_mipi_video_timing.sv
// Directed bench for mipi_video_timing on a 14x7 raster; a second instance runs
// with inverted sync polarity in lockstep from the same clock, reset and enable.
module tb_mipi_video_timing;
    import mipi_video_pkg::*;

    localparam int HT    = 14;
    localparam int VT    = 7;
    localparam int FT    = HT * VT;
    localparam int NOLIM = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vid_en = 1'b0;

    logic [23:0] pix_p, pix_n;
    logic [10:0] xpos_p, ypos_p, hdisp_p, vdisp_p;
    logic [10:0] xpos_n, ypos_n, hdisp_n, vdisp_n;
    logic        hs_p, vs_p, de_p, fs_p, busy_p;
    logic        hs_n, vs_n, de_n, fs_n, busy_n;
    logic [23:0] data_p, data_n;

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;

    always #5 clk = ~clk;

    // Pixel sources: registered echo of the requested column.
    always @(posedge clk) pix_p <= {13'd0, xpos_p};
    always @(posedge clk) pix_n <= {13'd0, xpos_n};

    mipi_video_timing #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .vid_en(vid_en), .pixel_data(pix_p),
        .pixel_xpos(xpos_p), .pixel_ypos(ypos_p), .h_disp(hdisp_p), .v_disp(vdisp_p),
        .vid_hs(hs_p), .vid_vs(vs_p), .vid_de(de_p), .vid_data(data_p),
        .frame_start(fs_p), .busy(busy_p)
    );

    mipi_video_timing #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_n (
        .clk(clk), .rst(rst), .vid_en(vid_en), .pixel_data(pix_n),
        .pixel_xpos(xpos_n), .pixel_ypos(ypos_n), .h_disp(hdisp_n), .v_disp(vdisp_n),
        .vid_hs(hs_n), .vid_vs(vs_n), .vid_de(de_n), .vid_data(data_n),
        .frame_start(fs_n), .busy(busy_n)
    );

    // Raster position q counts cycles from the frame_start cycle; positions
    // outside [0, lim) are idle. Active window: h in [4,12), v in [2,6).
    function automatic bit live(int q, int lim);
        return (q >= 0) && (q < lim);
    endfunction

    function automatic bit exp_act(int q, int lim);
        int h, v;
        if (!live(q, lim)) return 1'b0;
        h = q % HT;
        v = (q / HT) % VT;
        return (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
    endfunction

    function automatic logic [10:0] exp_x(int q, int lim);
        return exp_act(q, lim) ? 11'(q % HT - 4) : 11'd0;
    endfunction

    function automatic logic [10:0] exp_y(int q, int lim);
        return exp_act(q, lim) ? 11'((q / HT) % VT - 2) : 11'd0;
    endfunction

    function automatic logic [23:0] exp_data(int q, int lim);
        return {13'd0, exp_x(q, lim)};
    endfunction

    function automatic bit exp_hs(int q, int lim);
        return live(q, lim) && ((q % HT) < 2);
    endfunction

    function automatic bit exp_vs(int q, int lim);
        return live(q, lim) && (((q / HT) % VT) < 1);
    endfunction

    task automatic tick();
        @(negedge clk);
        pos++;
    endtask

    task automatic start_and_catch_frame(input string tag);
        vid_en = 1'b1;
        tick();
        n_checks++;
        if (fs_p !== 1'b0) begin n_fail++; $display("FAIL %s fs_early got=%b exp=0", tag, fs_p); end
        tick();
        n_checks++;
        if (fs_p !== 1'b1) begin n_fail++; $display("FAIL %s fs_pulse got=%b exp=1", tag, fs_p); end
        pos = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vid_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({xpos_p, ypos_p} !== 22'd0) begin n_fail++; $display("FAIL reset_xy got=%h exp=0", {xpos_p, ypos_p}); end
        n_checks++;
        if ({de_p, fs_p, busy_p, hs_p, vs_p} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctl de/fs/busy/hs/vs got=%b exp=00000", {de_p, fs_p, busy_p, hs_p, vs_p});
        end
        n_checks++;
        if (data_p !== 24'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_p); end
        n_checks++;
        if ({hs_n, vs_n} !== 2'b11) begin n_fail++; $display("FAIL reset_sync_inv got=%b exp=11", {hs_n, vs_n}); end
        n_checks++;
        if ({hdisp_p, vdisp_p} !== {11'd8, 11'd4}) begin
            n_fail++; $display("FAIL disp_const got=%0d/%0d exp=8/4", hdisp_p, vdisp_p);
        end
        n_checks++;
        if (dut_p.state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut_p.state, IDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sync_timing();
        int hs_cnt = 0;
        int first_hs = -1;
        start_and_catch_frame("start");
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (fs_p !== (pos % FT == 0)) begin n_fail++; $display("FAIL frame_start pos=%0d got=%b", pos, fs_p); end
            n_checks++;
            if (busy_p !== 1'b1) begin n_fail++; $display("FAIL busy_run pos=%0d got=%b exp=1", pos, busy_p); end
            n_checks++;
            if (hs_p !== exp_hs(pos - 2, NOLIM)) begin
                n_fail++; $display("FAIL hsync pos=%0d got=%b exp=%b", pos, hs_p, exp_hs(pos - 2, NOLIM));
            end
            if (pos >= 2 && hs_p === 1'b1) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = pos;
            end
            tick();
        end
        n_checks++;
        if (hs_cnt != 14) begin n_fail++; $display("FAIL hs_per_frame got=%0d exp=14", hs_cnt); end
        n_checks++;
        if (first_hs != 2) begin n_fail++; $display("FAIL hs_first got=%0d exp=2", first_hs); end
    endtask

    task automatic test_pixel_data();
        int run = 0;
        int lines = 0;
        for (int i = 0; i < FT; i++) begin
            n_checks++;
            if (de_p !== exp_act(pos - 2, NOLIM)) begin
                n_fail++; $display("FAIL de pos=%0d got=%b exp=%b", pos, de_p, exp_act(pos - 2, NOLIM));
            end
            n_checks++;
            if (data_p !== exp_data(pos - 2, NOLIM)) begin
                n_fail++; $display("FAIL data pos=%0d got=%h exp=%h", pos, data_p, exp_data(pos - 2, NOLIM));
            end
            if (de_p === 1'b1) begin
                n_checks++;
                if (data_p !== 24'(run)) begin n_fail++; $display("FAIL data_step pos=%0d got=%0d exp=%0d", pos, data_p, run); end
                run++;
            end else if (run != 0) begin
                n_checks++;
                if (run != 8) begin n_fail++; $display("FAIL de_run pos=%0d got=%0d exp=8", pos, run); end
                lines++;
                run = 0;
            end
            tick();
        end
        n_checks++;
        if (lines != 4) begin n_fail++; $display("FAIL de_lines got=%0d exp=4", lines); end
    endtask

    task automatic test_ypos_vsync();
        int vs_cnt = 0;
        for (int i = 0; i < FT; i++) begin
            n_checks++;
            if (xpos_p !== exp_x(pos, NOLIM)) begin n_fail++; $display("FAIL xpos pos=%0d got=%0d exp=%0d", pos, xpos_p, exp_x(pos, NOLIM)); end
            n_checks++;
            if (ypos_p !== exp_y(pos, NOLIM)) begin n_fail++; $display("FAIL ypos pos=%0d got=%0d exp=%0d", pos, ypos_p, exp_y(pos, NOLIM)); end
            n_checks++;
            if (vs_p !== exp_vs(pos - 2, NOLIM)) begin n_fail++; $display("FAIL vsync pos=%0d got=%b exp=%b", pos, vs_p, exp_vs(pos - 2, NOLIM)); end
            if (vs_p === 1'b1) vs_cnt++;
            tick();
        end
        n_checks++;
        if (vs_cnt != 14) begin n_fail++; $display("FAIL vs_per_frame got=%0d exp=14", vs_cnt); end
    endtask

    task automatic test_polarity();
        for (int i = 0; i < FT; i++) begin
            n_checks++;
            if ({hs_n, vs_n} !== {~exp_hs(pos - 2, NOLIM), ~exp_vs(pos - 2, NOLIM)}) begin
                n_fail++; $display("FAIL inv_sync pos=%0d got=%b%b", pos, hs_n, vs_n);
            end
            n_checks++;
            if (de_n !== exp_act(pos - 2, NOLIM) || data_n !== exp_data(pos - 2, NOLIM)) begin
                n_fail++; $display("FAIL inv_de_data pos=%0d got=%b/%h exp=%b/%h", pos, de_n, data_n,
                                   exp_act(pos - 2, NOLIM), exp_data(pos - 2, NOLIM));
            end
            tick();
        end
    endtask

    task automatic test_stop_at_frame_end();
        int stop_end;
        while (pos % FT != 30) tick();
        stop_end = pos - 30 + FT;
        vid_en = 1'b0;
        while (pos < stop_end + 40) begin
            n_checks++;
            if (busy_p !== (pos < stop_end)) begin n_fail++; $display("FAIL busy_drain pos=%0d got=%b", pos, busy_p); end
            n_checks++;
            if (fs_p !== 1'b0) begin n_fail++; $display("FAIL fs_drain pos=%0d got=%b exp=0", pos, fs_p); end
            n_checks++;
            if (xpos_p !== exp_x(pos, stop_end) || ypos_p !== exp_y(pos, stop_end)) begin
                n_fail++; $display("FAIL xy_drain pos=%0d got=%0d,%0d", pos, xpos_p, ypos_p);
            end
            n_checks++;
            if ({hs_p, vs_p, de_p} !== {exp_hs(pos - 2, stop_end), exp_vs(pos - 2, stop_end), exp_act(pos - 2, stop_end)}) begin
                n_fail++; $display("FAIL video_drain pos=%0d got=%b%b%b", pos, hs_p, vs_p, de_p);
            end
            n_checks++;
            if (data_p !== exp_data(pos - 2, stop_end)) begin
                n_fail++; $display("FAIL data_drain pos=%0d got=%h exp=%h", pos, data_p, exp_data(pos - 2, stop_end));
            end
            tick();
        end
        n_checks++;
        if (dut_p.state !== IDLE) begin n_fail++; $display("FAIL drain_state got=%0d exp=%0d", dut_p.state, IDLE); end
    endtask

    task automatic test_reset_mid_frame();
        start_and_catch_frame("restart");
        while (pos < 34) tick();
        n_checks++;
        if (de_p !== 1'b1 || data_p !== 24'd0) begin n_fail++; $display("FAIL pre_rst_active got=%b/%h exp=1/0", de_p, data_p); end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({de_p, fs_p, busy_p, hs_p, vs_p} !== 5'b00000 || data_p !== 24'd0) begin
            n_fail++; $display("FAIL rst_mid_out got=%b/%h exp=00000/0", {de_p, fs_p, busy_p, hs_p, vs_p}, data_p);
        end
        n_checks++;
        if (dut_p.h_cnt !== 12'd0 || dut_p.v_cnt !== 12'd0 || dut_p.state !== IDLE) begin
            n_fail++; $display("FAIL rst_mid_cnt got=%0d,%0d,%0d exp=0,0,%0d", dut_p.h_cnt, dut_p.v_cnt, dut_p.state, IDLE);
        end
        n_checks++;
        if ({xpos_p, ypos_p} !== 22'd0) begin n_fail++; $display("FAIL rst_mid_xy got=%h exp=0", {xpos_p, ypos_p}); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (fs_p !== 1'b0) begin n_fail++; $display("FAIL post_rst_fs_early got=%b exp=0", fs_p); end
        tick();
        n_checks++;
        if (fs_p !== 1'b1) begin n_fail++; $display("FAIL post_rst_fs got=%b exp=1", fs_p); end
        pos = 0;
        for (int i = 0; i < 30; i++) begin
            n_checks++;
            if (hs_p !== exp_hs(pos - 2, NOLIM) || de_p !== exp_act(pos - 2, NOLIM) || xpos_p !== exp_x(pos, NOLIM)) begin
                n_fail++; $display("FAIL post_rst_video pos=%0d got=%b%b/%0d", pos, hs_p, de_p, xpos_p);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sync_timing();
        test_pixel_data();
        test_ypos_vsync();
        test_polarity();
        test_stop_at_frame_end();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at pos=%0d", pos);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mipi_video_timing.md
Name: mipi_video_timing

Overview:
- Display timing driver on the request side of the pixel-coordinate interface.
- Generates horizontal/vertical counters and drives pixel_xpos, pixel_ypos, h_disp and v_disp to a pattern/pixel source, which returns pixel_data with exactly 1 registered cycle of latency.
- Realigns the returned pixel_data with regenerated hsync, vsync and data-enable, and presents them as one video stream to the MIPI DSI packetiser.
- Supports frame-boundary start and stop under an enable input.

Parameters:
- H_SYNC, 10, hsync width in clocks
- H_BACK, 40, horizontal back porch
- H_DISP, 720, active pixels per line (must be ≤ 2047)
- H_FRONT, 40, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 16, vertical back porch
- V_DISP, 1280, active lines (must be ≤ 2047)
- V_FRONT, 16, vertical front porch
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- vid_en  in  1  run request; sampled every cycle
- pixel_data  in  24  RGB888 from pixel source; valid 1 cycle after its coordinates
- pixel_xpos  out  11  active-area column; 0 outside active area
- pixel_ypos  out  11  active-area row; 0 outside active area
- h_disp  out  11  constant H_DISP
- v_disp  out  11  constant V_DISP
- vid_hs  out  1  hsync, polarity HS_POL
- vid_vs  out  1  vsync, polarity VS_POL
- vid_de  out  1  active-pixel enable
- vid_data  out  24  pixel data, 0 when vid_de=0
- frame_start  out  1  1-cycle pulse at h_cnt=0, v_cnt=0 while in RUN
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - h_cnt, v_cnt, pixel_xpos, pixel_ypos, vid_de, vid_data, frame_start and busy are all 0.
  - vid_hs = ~HS_POL and vid_vs = ~VS_POL (sync inactive).
  - State = IDLE.
- Derived constants:
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
  - HA_START = H_SYNC + H_BACK; VA_START = V_SYNC + V_BACK.
  - Counters are 12-bit unsigned.
- States:
  - IDLE: counters held at 0, all video outputs inactive. If vid_en=1, go to RUN on the next edge; counting starts from h=0, v=0.
  - RUN: h_cnt increments every cycle and wraps at H_TOTAL-1 to 0. v_cnt increments on each h wrap and wraps at V_TOTAL-1 to 0. If vid_en=0, go to DRAIN.
  - DRAIN: counting continues. If vid_en returns to 1, go back to RUN. At the last pixel of the frame (h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1), go to IDLE with counters reset to 0. A frame is never truncated.
- Stage 0 (registered from the counters, cycle t):
  - active0 = (h_cnt in [HA_START, HA_START+H_DISP)) and (v_cnt in [VA_START, VA_START+V_DISP)), and state ≠ IDLE.
  - pixel_xpos = h_cnt - HA_START when active0, else 0. pixel_ypos is formed the same way from v_cnt.
  - hs0 = (h_cnt < H_SYNC); vs0 = (v_cnt < V_SYNC). Both are inactive in IDLE.
- Stage 1:
  - de1, hs1 and vs1 are hs0/vs0/active0 delayed by 1 cycle, aligned with the returned pixel_data.
- Stage 2 (output registers):
  - vid_de = de1.
  - vid_hs = hs1 ? HS_POL : ~HS_POL; vid_vs likewise.
  - vid_data = de1 ? pixel_data : 0.
  - Total coordinate-to-output latency is 2 cycles, identical for every output signal.
- frame_start and busy are registered on stage 0 timing. They are not delayed.
- Pipeline flush on return to IDLE: the two pipeline stages finish naturally, since the last frame's tail is blanking.
- Reset mid-frame: takes effect on the next edge. All outputs return to reset values, pipeline contents are discarded, and there is no partial-line output.
- vid_en toggling inside a frame has no visible effect on the timing outputs.

Decomposition:
- Package mipi_video_pkg holds:
  - default timing constants (720x1280 set above);
  - RGB888 width (24);
  - coordinate width (11);
  - the state enum IDLE/RUN/DRAIN.
- Sub-module timing_counter: one instance each for h and v. It has inc, wrap-at-TOTAL and clear, and outputs cnt and wrap.
- The top level holds the FSM, the stage 0 decode and the 2-stage alignment pipeline.

Test Plan:
All tests use small timing parameters: H = 2/2/8/2 (total 14), V = 1/1/4/1 (total 7).
1. Reset, then vid_en=1 → frame_start pulses one cycle later. vid_hs is active for exactly 2 cycles every 14 cycles, first seen 2 cycles after frame_start.
2. pixel source is a registered echo, pixel_data <= {13'd0, pixel_xpos} → vid_de is high for 8 consecutive cycles per active line. vid_data steps 0..7 with no skew. There are 4 such lines per frame.
3. Check pixel_ypos → it reads 0,1,2,3 on active lines and is 0 in blanking. vid_vs is active for 1 line (14 cycles) per 98-cycle frame.
4. vid_en dropped mid-frame → the frame completes to cycle 97. busy falls at the frame end, IDLE holds outputs inactive, and no second frame_start follows.
5. rst asserted during an active line → the next cycle shows vid_de=0, vid_data=0, counters at 0 and state IDLE. After release with vid_en=1, output matches test 1.
6. HS_POL=0, VS_POL=0 → sync outputs are inverted, and de/data timing is unchanged.
